uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer sharing one UART transmitter among N_REQ word-wide requesters (debug/status sources).
- Grants one requester at a time and latches its word.
- Pulses the transmitter start, tracks its done flag through busy-then-done, and acknowledges the requester.
- Sits between the requesters and the uart_transmitter start/data/done interface.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side signal bundle for uart_tx_arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
   parameter int DATA_BITS = 32,
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2
);
   logic [N_REQ-1:0]           i_req;
   logic [N_REQ*DATA_BITS-1:0] i_req_data;
   logic [N_REQ-1:0]           o_ack;
   logic                       o_tx_start;
   logic [DATA_BITS-1:0]       o_tx_data;
   logic                       i_tx_done;
   logic [ID_W-1:0]            o_grant_id;
   logic                       o_busy;
   logic                       o_err;

   modport master (
      input  i_req, i_req_data, i_tx_done,
      output o_ack, o_tx_start, o_tx_data, o_grant_id, o_busy, o_err
   );

   modport slave (
      output i_req, i_req_data, i_tx_done,
      input  o_ack, o_tx_start, o_tx_data, o_grant_id, o_busy, o_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ word-wide requesters.
// Define UART_TX_ARB_TAG_EN to send a tag word (MSB set, grant id in the LSBs) before each data word.
module uart_tx_arbiter #(
   parameter int DATA_BITS = 32,
   parameter int N_REQ     = 4,
   parameter int ID_W      = 2,
   parameter int TIMEOUT   = 1024
) (
   input logic               i_clk,
   input logic               i_reset_n,
   uart_tx_arbiter_if.master bus
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE          = 3'd0;
   localparam logic [2:0] S_START         = 3'd1;
   localparam logic [2:0] S_WAIT_BUSY     = 3'd2;
   localparam logic [2:0] S_WAIT_DONE     = 3'd3;
   localparam logic [2:0] S_ACK           = 3'd4;
`ifdef UART_TX_ARB_TAG_EN
   localparam logic [2:0] S_START_TAG     = 3'd5;
   localparam logic [2:0] S_WAIT_BUSY_TAG = 3'd6;
   localparam logic [2:0] S_WAIT_DONE_TAG = 3'd7;
`endif

   logic [2:0]           state, state_nx;
   logic [CNT_W-1:0]     cnt;
   logic                 cnt_last;
   logic                 timeout;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      pick;
   logic                 found;
   logic [DATA_BITS-1:0] pick_word;
`ifdef UART_TX_ARB_TAG_EN
   logic [DATA_BITS-1:0] tag_word;
   logic [DATA_BITS-1:0] data_hold;
`endif

   assign cnt_last = (cnt == CNT_LAST);

   // Round-robin search: first set request strictly after the last served index, wrapping.
   always_comb begin
      int cand;
      // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
      found     = 1'b0;
      pick      = ptr;
      pick_word = '0;
      cand      = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(ptr) + i) % N_REQ;
         if (!found && bus.i_req[ID_W'(cand)]) begin
            found = 1'b1;
            pick  = ID_W'(cand);
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (pick == ID_W'(k)) pick_word = bus.i_req_data[k*DATA_BITS +: DATA_BITS];
      end
`ifdef UART_TX_ARB_TAG_EN
      tag_word                = '0;
      tag_word[DATA_BITS-1]   = 1'b1;
      tag_word[ID_W-1:0]      = pick;
`endif
   end

   always_comb begin
      state_nx = state;
      timeout  = 1'b0;
      case (state)
         S_IDLE: begin
`ifdef UART_TX_ARB_TAG_EN
            if (found) state_nx = S_START_TAG;
`else
            if (found) state_nx = S_START;
`endif
         end
         S_START: state_nx = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!bus.i_tx_done)  state_nx = S_WAIT_DONE;
            else if (cnt_last) begin
               state_nx = S_ACK;
               timeout  = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (bus.i_tx_done)   state_nx = S_ACK;
            else if (cnt_last) begin
               state_nx = S_ACK;
               timeout  = 1'b1;
            end
         end
         S_ACK: state_nx = S_IDLE;
`ifdef UART_TX_ARB_TAG_EN
         S_START_TAG: state_nx = S_WAIT_BUSY_TAG;
         S_WAIT_BUSY_TAG: begin
            if (!bus.i_tx_done)  state_nx = S_WAIT_DONE_TAG;
            else if (cnt_last) begin
               state_nx = S_ACK;
               timeout  = 1'b1;
            end
         end
         S_WAIT_DONE_TAG: begin
            if (bus.i_tx_done)   state_nx = S_START;
            else if (cnt_last) begin
               state_nx = S_ACK;
               timeout  = 1'b1;
            end
         end
`endif
         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each pulse lines up with its state's cycle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         ptr            <= ID_W'(N_REQ - 1);
         bus.o_ack      <= '0;
         bus.o_tx_start <= 1'b0;
         bus.o_tx_data  <= '0;
         bus.o_grant_id <= '0;
         bus.o_busy     <= 1'b0;
         bus.o_err      <= 1'b0;
`ifdef UART_TX_ARB_TAG_EN
         data_hold      <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state      <= state_nx;
         cnt        <= (state_nx == state && state != S_IDLE) ? cnt + 1'b1 : '0;
         bus.o_busy <= (state_nx != S_IDLE);
         bus.o_ack  <= (state_nx == S_ACK) ? (N_REQ'(1) << bus.o_grant_id) : '0;
`ifdef UART_TX_ARB_TAG_EN
         bus.o_tx_start <= (state_nx == S_START) || (state_nx == S_START_TAG);
`else
         bus.o_tx_start <= (state_nx == S_START);
`endif
         if (timeout) bus.o_err <= 1'b1;
         if (state == S_ACK) ptr <= bus.o_grant_id;
         if (state == S_IDLE && found) begin
            bus.o_grant_id <= pick;
`ifdef UART_TX_ARB_TAG_EN
            bus.o_tx_data  <= tag_word;
            data_hold      <= pick_word;
`else
            bus.o_tx_data  <= pick_word;
`endif
         end
`ifdef UART_TX_ARB_TAG_EN
         if (state == S_WAIT_DONE_TAG && state_nx == S_START) bus.o_tx_data <= data_hold;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected (grant id, word) per start pulse.
module tb_uart_tx_arbiter;
   localparam int DATA_BITS = 32;
   localparam int N_REQ     = 4;
   localparam int ID_W      = 2;
   localparam int TIMEOUT   = 16;

   typedef struct {
      logic [ID_W-1:0]      id;
      logic [DATA_BITS-1:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.DATA_BITS(DATA_BITS), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

   uart_tx_arbiter #(
      .DATA_BITS(DATA_BITS), .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
   );

   exp_t            sb[$];
   int              n_checks = 0;
   int              n_pass   = 0;
   int              ack_cnt  = 0;
   int              ack_per [N_REQ];
   int              snap    [N_REQ];
   logic [ID_W-1:0] cur_id   = '0;
   bit              start_pending = 1'b0;
   bit              tx_alive = 1'b1;
   int              tx_len   = 16;   // longest transfer that still fits inside TIMEOUT
   logic [DATA_BITS-1:0] words [N_REQ] = '{32'hDEADBEEF, 32'h0BADF00D, 32'h12345678, 32'hCAFEBABE};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

`ifdef UART_TX_ARB_TAG_EN
   function automatic logic [DATA_BITS-1:0] tag_of(input logic [ID_W-1:0] id);
      logic [DATA_BITS-1:0] t;
      t              = '0;
      t[DATA_BITS-1] = 1'b1;
      t[ID_W-1:0]    = id;
      return t;
   endfunction
`endif

   task automatic expect_grant(input logic [ID_W-1:0] id, input logic [DATA_BITS-1:0] data);
      exp_t e;
      e.id = id;
`ifdef UART_TX_ARB_TAG_EN
      e.data = tag_of(id);
      sb.push_back(e);
`endif
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_acks(input int target, input int budget, input string tag);
      int c = 0;
      while (ack_cnt < target && c < budget) begin
         tick();
         c++;
      end
      check(tag, 64'(ack_cnt), 64'(target));
   endtask

   task automatic wait_start(input int budget, input string tag);
      int c = 0;
      while (!bus.o_tx_start && c < budget) begin
         tick();
         c++;
      end
      check(tag, bus.o_tx_start, 1);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      bus.i_req = '0;
      repeat (3) tick();
      sb.delete();
      start_pending = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   // Monitor: every start pops one expected word; every ack must match the served id once.
   initial begin
      exp_t e;
      foreach (ack_per[k]) ack_per[k] = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.o_tx_start) begin
               check("sb_has_entry", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("start_data", bus.o_tx_data, e.data);
                  check("start_grant_id", bus.o_grant_id, e.id);
                  cur_id        = e.id;
                  start_pending = 1'b1;
               end
            end
            if (bus.o_ack != '0) begin
               check("ack_onehot", bus.o_ack, N_REQ'(1) << cur_id);
               check("ack_has_start", start_pending, 1);
               start_pending = 1'b0;
               ack_cnt++;
               for (int k = 0; k < N_REQ; k++) if (bus.o_ack[k]) ack_per[k]++;
            end
         end
      end
   end

   // Transmitter model: done drops two cycles after start, rises tx_len cycles later.
   initial begin
      bus.i_tx_done = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n && bus.o_tx_start && tx_alive) begin
            repeat (2) @(posedge clk);
            #1 bus.i_tx_done = 1'b0;
            repeat (tx_len) @(posedge clk);
            #1 bus.i_tx_done = 1'b1;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      bus.i_req      = '0;
      bus.i_req_data = {words[3], words[2], words[1], words[0]};
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_tx_start", bus.o_tx_start, 0);
      check("rst_ack", bus.o_ack, 0);
      check("rst_tx_data", bus.o_tx_data, 0);
      check("rst_grant_id", bus.o_grant_id, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_err", bus.o_err, 0);
      rst_n = 1'b1;
      tick();

      // Single request, start one cycle after the sampling edge.
      base = ack_cnt;
      expect_grant(0, words[0]);
      bus.i_req = 4'b0001;
      tick();
      check("s1_latency_start", bus.o_tx_start, 1);
      check("s1_busy", bus.o_busy, 1);
      check("s1_grant_id", bus.o_grant_id, 0);
      wait_acks(base + 1, 200, "s1_ack_seen");
      bus.i_req = '0;
      check("s1_ack_value", bus.o_ack, 4'b0001);
      check("s1_err", bus.o_err, 0);
      repeat (3) tick();
      check("s1_data_hold", bus.o_tx_data, 32'hDEADBEEF);
      check("s1_single_ack", 64'(ack_cnt), 64'(base + 1));
      check("s1_idle", bus.o_busy, 0);
      check("s1_sb_empty", 64'(sb.size()), 0);

      // All four requesting from reset: strict order 0,1,2,3,0,1,2,3.
      do_reset();
      foreach (snap[k]) snap[k] = ack_per[k];
      base = ack_cnt;
      for (int r = 0; r < 8; r++) expect_grant(ID_W'(r % N_REQ), words[r % N_REQ]);
      bus.i_req = 4'b1111;
      wait_acks(base + 8, 8 * 80, "s2_acks_seen");
      bus.i_req = '0;
      repeat (3) tick();
      for (int k = 0; k < N_REQ; k++) check("s2_acks_per_req", 64'(ack_per[k] - snap[k]), 2);
      check("s2_last_grant", bus.o_grant_id, 3);
      check("s2_sb_empty", 64'(sb.size()), 0);

      // 1 and 3 held after grant 3; 2 raised during 3's transfer lands before 3's second word.
      base = ack_cnt;
      expect_grant(1, words[1]);
      expect_grant(3, words[3]);
      expect_grant(1, words[1]);
      expect_grant(2, words[2]);
      expect_grant(3, words[3]);
      bus.i_req = 4'b1010;
      wait_acks(base + 1, 200, "s3_first_ack");
      wait_start(20, "s3_second_start");
      bus.i_req[2] = 1'b1;
      wait_acks(base + 5, 5 * 80, "s3_acks_seen");
      bus.i_req = '0;
      repeat (3) tick();
      check("s3_sb_empty", 64'(sb.size()), 0);

      // Transmitter never responds: error after TIMEOUT cycles in the busy wait, ack still sent.
      tx_alive = 1'b0;
      begin
         exp_t e;
         e.id = 0;
`ifdef UART_TX_ARB_TAG_EN
         e.data = tag_of(0);
`else
         e.data = words[0];
`endif
         sb.push_back(e);
      end
      bus.i_req = 4'b0001;
      wait_start(20, "s4_start");
      base = ack_cnt;
      repeat (TIMEOUT) tick();
      check("s4_err_not_yet", bus.o_err, 0);
      check("s4_no_early_ack", 64'(ack_cnt), 64'(base));
      tick();
      check("s4_err_set", bus.o_err, 1);
      check("s4_ack_after_timeout", 64'(ack_cnt), 64'(base + 1));
      bus.i_req = '0;
      tx_alive  = 1'b1;
      repeat (3) tick();
      base = ack_cnt;
      expect_grant(1, words[1]);
      bus.i_req = 4'b0010;
      wait_acks(base + 1, 200, "s4_next_ack");
      bus.i_req = '0;
      repeat (2) tick();
      check("s4_err_sticky", bus.o_err, 1);
      check("s4_next_grant", bus.o_grant_id, 1);
      check("s4_sb_empty", 64'(sb.size()), 0);

      // Reset while the transmitter is busy: outputs clear at once, no ack.
      expect_grant(0, words[0]);
      bus.i_req = 4'b0001;
      wait_start(20, "s5_start");
      base = ack_cnt;
      repeat (6) tick();
      check("s5_busy_mid", bus.o_busy, 1);
      check("s5_done_low", bus.i_tx_done, 0);
      #2 rst_n = 1'b0;
      #1;
      check("s5_rst_tx_start", bus.o_tx_start, 0);
      check("s5_rst_ack", bus.o_ack, 0);
      check("s5_rst_tx_data", bus.o_tx_data, 0);
      check("s5_rst_grant_id", bus.o_grant_id, 0);
      check("s5_rst_busy", bus.o_busy, 0);
      check("s5_rst_err", bus.o_err, 0);
      sb.delete();
      start_pending = 1'b0;
      bus.i_req     = '0;
      repeat (30) tick();
      check("s5_no_ack", 64'(ack_cnt), 64'(base));
      rst_n = 1'b1;
      tick();
      expect_grant(2, words[2]);
      bus.i_req = 4'b0100;
      tick();
      check("s5_restart", bus.o_tx_start, 1);
      check("s5_grant_id", bus.o_grant_id, 2);
      wait_acks(base + 1, 200, "s5_ack_seen");
      bus.i_req = '0;
      repeat (3) tick();
      check("s5_err_clear", bus.o_err, 0);
      check("s5_one_ack", 64'(ack_cnt), 64'(base + 1));
      check("s5_sb_empty", 64'(sb.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
